// File: rtl/fft_twiddle_feeder_if.sv
// Handshake bundle between the lower-leg sample stream, the twiddle feeder and
// the complex multiplier that consumes the operand pair.
interface fft_twiddle_feeder_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        inverse;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_op1;
   logic [63:0] out_op2;
   logic        out_last;
   logic [3:0]  out_stage;
   logic        frame_done;

   modport slave (
      input  in_valid, in_data, inverse, out_ready,
      output in_ready, out_valid, out_op1, out_op2, out_last, out_stage, frame_done
   );

   modport master (
      output in_valid, in_data, inverse, out_ready,
      input  in_ready, out_valid, out_op1, out_op2, out_last, out_stage, frame_done
   );
endinterface

// File: rtl/fft_twiddle_feeder.sv
// Pairs each lower-leg butterfly sample with its radix-2 DIT twiddle factor and
// presents both as a registered operand pair, sequencing stages frame by frame.
module fft_twiddle_feeder #(
   parameter int N     = 8,
   parameter int LOG2N = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   fft_twiddle_feeder_if.slave bus
);
   localparam logic [3:0] LAST_BEAT  = 4'(N / 2 - 1);
   localparam logic [3:0] LAST_STAGE = 4'(LOG2N - 1);

   logic [3:0]  m;
   logic [3:0]  s;
   logic        inv_q;
   logic        xfer;
   logic        inv_eff;
   logic [3:0]  j;
   logic [2:0]  rom_addr;
   logic [63:0] rom_word;
   logic [63:0] twiddle;

   // W16^a = cos(2*pi*a/16) - j*sin(2*pi*a/16), single precision {re, im}.
   function automatic logic [63:0] rom(input logic [2:0] a);
      case (a)
         3'd0: rom = 64'h3F800000_00000000;
         3'd1: rom = 64'h3F6C835E_BEC3EF15;
         3'd2: rom = 64'h3F3504F3_BF3504F3;
         3'd3: rom = 64'h3EC3EF15_BF6C835E;
         3'd4: rom = 64'h00000000_BF800000;
         3'd5: rom = 64'hBEC3EF15_BF6C835E;
         3'd6: rom = 64'hBF3504F3_BF3504F3;
         3'd7: rom = 64'hBF6C835E_BEC3EF15;
      endcase
   endfunction

   assign bus.in_ready   = !bus.out_valid || bus.out_ready;
   assign bus.frame_done = bus.out_valid && bus.out_ready && bus.out_last;
   assign xfer           = bus.in_valid && bus.in_ready;

   // NOTE: every variable gets a value on every pass through always_comb, so no latch is inferred.
   always_comb begin
      j        = m & ((4'd1 << s) - 4'd1);
      // (j << (LOG2N-1-s)) * (16/N) collapses to j << (3-s) for every legal N.
      rom_addr = 3'(j << (4'd3 - s));
      rom_word = rom(rom_addr);
      inv_eff  = (m == 4'd0) ? bus.inverse : inv_q;
      twiddle  = {rom_word[63:32], rom_word[31] ^ inv_eff, rom_word[30:0]};
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_op1   <= '0;
         bus.out_op2   <= '0;
         bus.out_last  <= 1'b0;
         bus.out_stage <= '0;
         m             <= '0;
         s             <= '0;
         inv_q         <= 1'b0;
      end else if (xfer) begin
         bus.out_valid <= 1'b1;
         bus.out_op1   <= bus.in_data;
         bus.out_op2   <= twiddle;
         bus.out_last  <= (m == LAST_BEAT);
         bus.out_stage <= s;
         inv_q         <= inv_eff;
         if (m == LAST_BEAT) begin
            m <= '0;
            s <= (s == LAST_STAGE) ? 4'd0 : s + 4'd1;
         end else begin
            m <= m + 4'd1;
         end
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: doc/fft_twiddle_feeder.md
Name: fft_twiddle_feeder

Overview:
- Sits directly upstream of the complex multiplier in the butterfly FFT datapath.
- Accepts the stream of lower-leg butterfly samples (64-bit packed {real[63:32], imag[31:0]}, IEEE-754 single precision).
- Pairs each sample with the correct radix-2 DIT twiddle factor from an internal constant ROM.
- Presents both as a registered operand pair (op1 = sample, op2 = twiddle) with a valid/ready handshake; auto-sequences stages frame by frame.

Parameters:
- N, 8, FFT size in points; legal values 2, 4, 8, 16.
- LOG2N, 3, log2(N); must match N.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  64  sample {re,im}.
- inverse  input  1  1 = conjugate twiddles (IFFT); sampled on first beat of each frame.
- out_valid  output  1  operand pair valid.
- out_ready  input  1  downstream accepts pair.
- out_op1  output  64  registered sample.
- out_op2  output  64  registered twiddle {re,im}.
- out_last  output  1  pair is last beat of frame (beat N/2-1).
- out_stage  output  4  stage index of current pair, zero-extended.
- frame_done  output  1  one-cycle pulse when the last beat of a frame is accepted downstream.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_op1=0, out_op2=0, out_last=0, out_stage=0, frame_done=0, beat counter m=0, stage s=0, latched inverse=0. Mid-frame reset discards the partial frame; the next accepted sample is beat 0 of stage 0.
- Handshake: in_ready = !out_valid || out_ready (combinational). A transfer occurs when in_valid && in_ready. Output fields are held stable while out_valid && !out_ready.
- Latency: exactly 1 cycle from input transfer to out_valid. Full throughput is 1 pair per cycle with out_ready held at 1.
- Output register update: on an input transfer, load out_op1=in_data, out_op2=twiddle, out_last=(m==N/2-1), out_stage=s, and set out_valid=1. Otherwise, if out_ready, clear out_valid.
- Simultaneous output accept and new input transfer in the same cycle: out_valid stays 1 and the register reloads.
- Twiddle index: j = m mod 2^s; k = j << (LOG2N-1-s). The ROM address is k*(16/N).
- ROM (W16^a = cos - j·sin), a = 0..7:
  - a=0: {3F800000,00000000}
  - a=1: {3F6C835E,BEC3EF15}
  - a=2: {3F3504F3,BF3504F3}
  - a=3: {3EC3EF15,BF6C835E}
  - a=4: {00000000,BF800000}
  - a=5: {BEC3EF15,BF6C835E}
  - a=6: {BF3504F3,BF3504F3}
  - a=7: {BF6C835E,BEC3EF15}
- Inverse: when latched inverse=1, flip bit 31 of the twiddle (imag sign) and leave the real part unchanged. a=0 then gives imag 80000000.
- inverse is latched on the beat m=0 transfer and applies to the whole frame. Changes mid-frame are ignored.
- Counters: m increments on each input transfer and wraps from N/2-1 to 0.
- On that wrap, s increments and wraps from LOG2N-1 to 0.
- frame_done = 1 for one cycle when out_valid && out_ready && out_last.
- Back-pressure: counters advance only on input transfers, never on stalls.
- N=2 edge case: LOG2N=1, one beat per frame. s is always 0, so every twiddle is W^0 and out_last=1 on every pair.
- No arithmetic is performed on data; the twiddle values are exact constants.

Test Plan:
- Reset, then stream 4 samples at stage 0 (N=8), out_ready=1 -> every out_op2 = 3F800000_00000000; out_last on the 4th pair; frame_done pulses once; out_stage=0.
- Second frame (stage 1), in_data = 3F800000_00000000 -> out_op2 sequence {3F800000_00000000, 00000000_BF800000, 3F800000_00000000, 00000000_BF800000}; out_stage=1.
- Third frame (stage 2) -> out_op2 sequence {3F800000_00000000, 3F3504F3_BF3504F3, 00000000_BF800000, BF3504F3_BF3504F3}. The next frame returns to stage 0.
- Stage 2 with inverse=1 on beat 0, toggled to 0 at beat 2 -> beat 1 op2 = 3F3504F3_3F3504F3 and beat 3 op2 = BF3504F3_3F3504F3 (conjugate for the whole frame).
- Hold out_ready=0 for 5 cycles mid-frame with in_valid=1 -> in_ready=0 after the first load; out_op1/op2 stable; m does not advance. The sequence resumes correctly with no lost or duplicated beats.
- Assert rst_n=0 asynchronously at beat 2 of stage 1 -> outputs clear immediately; the next frame is stage 0 beat 0 with op2 = 3F800000_00000000.
